apb_uart_arb: RTL



---
 rtl/apb_uart_arb.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/apb_uart_arb.sv
// Round-robin arbiter sharing the UART APB slave port between the CPU bridge (0) and the byte mover (1).
// Optional UART_ARB_LOCK_EN adds LOCK0/LOCK1 so a requester can hold the bus for atomic sequences.
module apb_uart_arb #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          PCLK,
  input  logic          PRST_N,
  input  logic          REQ0,
  input  logic          REQ1,
  input  logic          WRITE0,
  input  logic          WRITE1,
  input  logic [AW-1:0] ADDR0,
  input  logic [AW-1:0] ADDR1,
  input  logic [DW-1:0] WDATA0,
  input  logic [DW-1:0] WDATA1,
`ifdef UART_ARB_LOCK_EN
  input  logic          LOCK0,
  input  logic          LOCK1,
`endif
  output logic          GNT0,
  output logic          GNT1,
  output logic          DONE0,
  output logic          DONE1,
  output logic [DW-1:0] RDATA,
  output logic          BUSY,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t        state_q, state_d;
  logic          ptr_q, ptr_d;
  logic          owner_q, owner_d;
  logic          locked_q, locked_d;
  logic          psel_q, psel_d;
  logic          penable_q, penable_d;
  logic          pwrite_q, pwrite_d;
  logic [AW-1:0] paddr_q, paddr_d;
  logic [DW-1:0] pwdata_q, pwdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          done0_q, done0_d;
  logic          done1_q, done1_d;
  logic          req_eff0, req_eff1, win, gnt0_c, gnt1_c;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    locked_d  = locked_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    req_eff0  = REQ0;
    req_eff1  = REQ1;
    win       = 1'b0;
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef UART_ARB_LOCK_EN
        // A held lock masks the other requester until the owner lets REQ go.
        if (locked_q) begin
          if (owner_q ? REQ1 : REQ0) begin
            req_eff0 = REQ0 & ~owner_q;
            req_eff1 = REQ1 & owner_q;
          end else begin
            locked_d = 1'b0;
          end
        end
`endif
        win = (req_eff0 && req_eff1) ? ptr_q : req_eff1;
        if (req_eff0 || req_eff1) begin
          gnt0_c   = ~win;
          gnt1_c   = win;
          pwrite_d = win ? WRITE1 : WRITE0;
          paddr_d  = win ? ADDR1 : ADDR0;
          pwdata_d = win ? WDATA1 : WDATA0;
          owner_d  = win;
          ptr_d    = ~win;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
`ifdef UART_ARB_LOCK_EN
          locked_d = win ? LOCK1 : LOCK0;
          if (locked_d) ptr_d = ptr_q;
`endif
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        done0_d   = ~owner_q;
        done1_d   = owner_q;
        if (!pwrite_q) rdata_d = PRDATA;
        state_d   = S_IDLE;
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      locked_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      locked_q  <= locked_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
    end
  end

  // Grants are decided combinationally in IDLE so a new SETUP can follow the DONE cycle directly.
  assign GNT0    = gnt0_c & PRST_N;
  assign GNT1    = gnt1_c & PRST_N;
  assign DONE0   = done0_q;
  assign DONE1   = done1_q;
  assign RDATA   = rdata_q;
  assign BUSY    = (state_q != S_IDLE);
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;

endmodule
